// File: rtl/led_pwm_pkg.sv
// Shared defaults and types for the LED PWM fader.
package led_pwm_pkg;

  localparam int LED_PWM_BITS       = 8;
  localparam int LED_NUM            = 14;
  localparam int LED_PRESCALE_50MHZ = 196;

  typedef logic [LED_PWM_BITS-1:0] level_t;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness level register, optional fade-out (LED_FADE_EN) and PWM comparator.
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int PWM_BITS = LED_PWM_BITS
`ifdef LED_FADE_EN
  , parameter int DECAY_STEP = 8
`endif
) (
`ifdef LED_FADE_EN
  input  logic                fade_step,
`endif
  input  logic                clk,
  input  logic                reset,
  input  logic                led_in,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_out
);

  logic [PWM_BITS-1:0] level_q, level_d;
  logic                led_out_q, led_out_d;

`ifdef LED_FADE_EN
  localparam logic [PWM_BITS-1:0] STEP_L = PWM_BITS'(DECAY_STEP);

  // Decrement that clamps at zero instead of wrapping.
  function automatic logic [PWM_BITS-1:0] sat_sub(input logic [PWM_BITS-1:0] lvl);
    return (lvl > STEP_L) ? lvl - STEP_L : '0;
  endfunction
`endif

  always_comb begin
    level_d   = level_q;
    if (led_in) begin
      level_d = brightness;
    end else begin
`ifdef LED_FADE_EN
      if (fade_step) level_d = sat_sub(level_q);
`else
      level_d = '0;
`endif
    end
    led_out_d = (level_q > pwm_cnt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q   <= '0;
      led_out_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      led_out_q <= led_out_d;
    end
  end

  assign led_out = led_out_q;

endmodule

// File: rtl/led_pwm_fader.sv
// LED PIO to pin driver: shared prescaler/PWM counter and per-channel PWM.
// Define LED_FADE_EN to make cleared channels fade out instead of switching off.
module led_pwm_fader
  import led_pwm_pkg::*;
#(
  parameter int NUM_LEDS      = LED_NUM,
  parameter int PWM_BITS      = LED_PWM_BITS,
  parameter int PRESCALE      = LED_PRESCALE_50MHZ,
  parameter int DECAY_PERIODS = 4,
  parameter int DECAY_STEP    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                pwm_sync
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("led_pwm_fader: PRESCALE must be >= 1");
  end
  if (DECAY_PERIODS < 1 || DECAY_STEP < 0 || DECAY_STEP >= (1 << PWM_BITS)) begin : g_bad_decay
    $error("led_pwm_fader: DECAY_PERIODS must be >= 1 and DECAY_STEP must fit in a level");
  end

  logic [PS_W-1:0]     prescale_cnt_q, prescale_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_sync_q, pwm_sync_d;
  logic                tick;

  always_comb begin
    tick           = (prescale_cnt_q == PS_LAST);
    prescale_cnt_d = tick ? '0 : prescale_cnt_q + 1'b1;
    pwm_cnt_d      = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    // Registered so the pulse lines up with the first clk of the new period.
    pwm_sync_d     = tick && (pwm_cnt_q == '1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_cnt_q <= '0;
      pwm_cnt_q      <= '0;
      pwm_sync_q     <= 1'b0;
    end else begin
      prescale_cnt_q <= prescale_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      pwm_sync_q     <= pwm_sync_d;
    end
  end

  assign pwm_sync = pwm_sync_q;

`ifdef LED_FADE_EN
  localparam int DC_W = (DECAY_PERIODS > 1) ? $clog2(DECAY_PERIODS) : 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DECAY_PERIODS - 1);

  logic [DC_W-1:0] decay_cnt_q, decay_cnt_d;
  logic            fade_step;

  always_comb begin
    decay_cnt_d = decay_cnt_q;
    fade_step   = pwm_sync_q && (decay_cnt_q == DC_LAST);
    if (pwm_sync_q) decay_cnt_d = (decay_cnt_q == DC_LAST) ? '0 : decay_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) decay_cnt_q <= '0;
    else       decay_cnt_q <= decay_cnt_d;
  end
`endif

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
`ifdef LED_FADE_EN
    led_pwm_channel #(
      .PWM_BITS   (PWM_BITS),
      .DECAY_STEP (DECAY_STEP)
    ) u_ch (
      .fade_step  (fade_step),
      .clk        (clk),
      .reset      (reset),
      .led_in     (led_in[i]),
      .brightness (brightness),
      .pwm_cnt    (pwm_cnt_q),
      .led_out    (led_out[i])
    );
`else
    led_pwm_channel #(
      .PWM_BITS   (PWM_BITS)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .led_in     (led_in[i]),
      .brightness (brightness),
      .pwm_cnt    (pwm_cnt_q),
      .led_out    (led_out[i])
    );
`endif
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed self-checking bench for led_pwm_fader (PRESCALE=2, PWM_BITS=8).
module tb_led_pwm_fader;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] led_in;
  logic [7:0]  brightness;
  logic [13:0] led_out;
  logic        pwm_sync;

  int errors = 0;
  int checks = 0;
  int n;  // posedges since reset release

  led_pwm_fader #(
    .NUM_LEDS      (14),
    .PWM_BITS      (8),
    .PRESCALE      (2),
    .DECAY_PERIODS (1),
    .DECAY_STEP    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .led_in     (led_in),
    .brightness (brightness),
    .led_out    (led_out),
    .pwm_sync   (pwm_sync)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_mod(input int m);
    int k = 0;
    while ((n % 512) != m && k < 1100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1100) chk("wait_mod_timeout", 1, 0);
  endtask

  task automatic wait_sync();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (pwm_sync !== 1'b1 && k < 600);
    if (k >= 600) chk("wait_sync_timeout", 1, 0);
  endtask

  // Samples len clks: high count on channel ch, clks with other bits lit, sync pulses, misplaced sync samples.
  task automatic measure(input int ch, input int len, output int hi, output int others,
                         output int syncs, output int sync_bad);
    logic [13:0] mask;
    logic        exp_sync;
    hi = 0; others = 0; syncs = 0; sync_bad = 0;
    mask = ~(14'h0001 << ch);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (led_out[ch]) hi++;
      if ((led_out & mask) != 14'h0) others++;
      if (pwm_sync) syncs++;
      exp_sync = (n > 0) && ((n % 512) == 0);
      if (pwm_sync !== exp_sync) sync_bad++;
    end
  endtask

  int hi, others, syncs, sync_bad;

  initial begin
    reset = 1'b1; led_in = '0; brightness = '0;
    #1;
    chk("reset_led_out", 32'(led_out), 0);
    chk("reset_pwm_sync", 32'(pwm_sync), 0);
    #19;
    @(negedge clk) reset = 1'b0;

    // Reset asserted mid-period with all LEDs lit
    brightness = 8'd128; led_in = '1;
    wait_mod(40);
    chk("all_on_before_reset", 32'(led_out), 32'h3fff);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_led_out", 32'(led_out), 0);
    chk("async_reset_pwm_sync", 32'(pwm_sync), 0);
    chk("async_reset_level", 32'(dut.g_ch[0].u_ch.level_q), 0);
    @(negedge clk) reset = 1'b0;
    chk("restart_pwm_cnt0", 32'(dut.pwm_cnt_q), 0);
    @(negedge clk);
    chk("no_glitch_after_release", 32'(led_out), 0);
    chk("pwm_cnt_after_1clk", 32'(dut.pwm_cnt_q), 0);
    @(negedge clk);
    chk("pwm_cnt_after_2clk", 32'(dut.pwm_cnt_q), 1);
    chk("all_on_after_release", 32'(led_out), 32'h3fff);

    // Duty at brightness 64 on channel 0 only
    led_in = 14'h0001; brightness = 8'd64;
    repeat (3) @(negedge clk);
    measure(0, 512, hi, others, syncs, sync_bad);
    chk("duty64_high_clks", hi, 128);
    chk("duty64_other_bits", others, 0);

    brightness = 8'd0;
    repeat (3) @(negedge clk);
    measure(0, 512, hi, others, syncs, sync_bad);
    chk("duty0_high_clks", hi, 0);

    brightness = 8'd255;
    repeat (3) @(negedge clk);
    measure(0, 512, hi, others, syncs, sync_bad);
    chk("duty255_high_clks", hi, 510);
    wait_mod(511);
    chk("duty255_low_at_cnt255_a", 32'(led_out[0]), 0);
    @(negedge clk);
    chk("duty255_low_at_cnt255_b", 32'(led_out[0]), 0);
    @(negedge clk);
    chk("duty255_high_at_cnt0", 32'(led_out[0]), 1);

    // pwm_sync period and width
    measure(0, 1024, hi, others, syncs, sync_bad);
    chk("sync_pulses_per_1024", syncs, 2);
    chk("sync_misplaced_samples", sync_bad, 0);

    // led_in rise latency
    led_in = '0; brightness = 8'd200;
    repeat (3) @(negedge clk);
    wait_mod(10);
    led_in = 14'h0002;
    @(negedge clk);
    chk("rise_level_1clk", 32'(dut.g_ch[1].u_ch.level_q), 200);
    chk("rise_led_out_1clk", 32'(led_out[1]), 0);
    @(negedge clk);
    chk("rise_led_out_2clk", 32'(led_out[1]), 1);

    // Fall behaviour with brightness 40 on channel 2
    led_in = 14'h0004; brightness = 8'd40;
    repeat (2) @(negedge clk);
    chk("fade_start_level", 32'(dut.g_ch[2].u_ch.level_q), 40);
`ifdef LED_FADE_EN
    wait_mod(100);
    led_in = '0;
    @(negedge clk);
    chk("fade_hold_level", 32'(dut.g_ch[2].u_ch.level_q), 40);
    wait_sync(); @(negedge clk);
    chk("fade_step1", 32'(dut.g_ch[2].u_ch.level_q), 32);
    wait_sync(); @(negedge clk);
    chk("fade_step2", 32'(dut.g_ch[2].u_ch.level_q), 24);
    wait_sync(); @(negedge clk);
    chk("fade_step3", 32'(dut.g_ch[2].u_ch.level_q), 16);
    wait_sync(); @(negedge clk);
    chk("fade_step4", 32'(dut.g_ch[2].u_ch.level_q), 8);
    wait_sync(); @(negedge clk);
    chk("fade_step5", 32'(dut.g_ch[2].u_ch.level_q), 0);
    wait_sync(); @(negedge clk);
    chk("fade_step6_stays0", 32'(dut.g_ch[2].u_ch.level_q), 0);
    led_in = 14'h0004;
    repeat (2) @(negedge clk);
    wait_mod(100);
    led_in = '0;
    wait_sync(); @(negedge clk);
    chk("refade_step1", 32'(dut.g_ch[2].u_ch.level_q), 32);
    led_in = 14'h0004;
    @(negedge clk);
    chk("reset_bit_mid_fade", 32'(dut.g_ch[2].u_ch.level_q), 40);
`else
    led_in = '0;
    @(negedge clk);
    chk("nofade_level_1clk", 32'(dut.g_ch[2].u_ch.level_q), 0);
    measure(2, 600, hi, others, syncs, sync_bad);
    chk("nofade_led_out_dark", hi, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
